// File: rtl/gpio_event_ctrl.sv
// Memory-mapped input-event controller: per-channel sync/debounce, edge events into W1C STATUS,
// masked active-low interrupt and a general output register. Define GPIO_LEVEL_RD_EN to expose LEVEL at 0x010.
module gpio_event_ctrl #(
  parameter int               N_IN    = 18,
  parameter int               DB_CNT  = 16,
  parameter int               N_OUT   = 32,
  parameter logic [N_OUT-1:0] OUT_RST = '0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              CS_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [11:0]       Addr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  input  logic [N_IN-1:0]   IN,
  output logic [N_OUT-1:0]  OUT,
  output logic              Intr
);

  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);

  localparam logic [11:0] ADDR_STATUS  = 12'h000;
  localparam logic [11:0] ADDR_MASK    = 12'h004;
  localparam logic [11:0] ADDR_RISE_EN = 12'h008;
  localparam logic [11:0] ADDR_FALL_EN = 12'h00C;
  localparam logic [11:0] ADDR_LEVEL   = 12'h010;
  localparam logic [11:0] ADDR_OUT     = 12'h014;

  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  logic [N_IN-1:0]  r_level;
  logic [N_IN-1:0]  r_status;
  logic [N_IN-1:0]  r_mask;
  logic [N_IN-1:0]  r_rise_en;
  logic [N_IN-1:0]  r_fall_en;
  logic [N_OUT-1:0] r_out;

  logic             w_wr;
  logic             w_rd;
  logic [N_IN-1:0]  w_flip;
  logic [N_IN-1:0]  w_set;
  logic [N_IN-1:0]  w_clr;
  logic [31:0]      w_rdata;

  assign w_wr = ~CS_N & ~WR_N;
  assign w_rd = ~CS_N & ~RD_N;

  // Per-channel debounce counter; w_flip marks the edge on which LEVEL takes the synchronised value.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_chan
      logic [CW-1:0] r_cnt;

      assign w_flip[gi] = (r_sync2[gi] != r_level[gi]) && (r_cnt == DB_LAST);

      always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if ((r_sync2[gi] == r_level[gi]) || w_flip[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  // On a flip the new level equals r_sync2, so r_sync2 distinguishes rising from falling.
  assign w_set = w_flip & ((r_sync2 & r_rise_en) | (~r_sync2 & r_fall_en));
  assign w_clr = (w_wr && (Addr == ADDR_STATUS)) ? DataIn[N_IN-1:0] : '0;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_status  <= '0;
      r_mask    <= '0;
      r_rise_en <= '1;
      r_fall_en <= '0;
      r_out     <= OUT_RST;
    end else begin
      r_sync1  <= IN;
      r_sync2  <= r_sync1;
      r_level  <= r_level ^ w_flip;
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_wr) begin
        case (Addr)
          ADDR_MASK:    r_mask    <= DataIn[N_IN-1:0];
          ADDR_RISE_EN: r_rise_en <= DataIn[N_IN-1:0];
          ADDR_FALL_EN: r_fall_en <= DataIn[N_IN-1:0];
          ADDR_OUT:     r_out     <= DataIn[N_OUT-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_rd) begin
      case (Addr)
        ADDR_STATUS:  w_rdata = 32'(r_status);
        ADDR_MASK:    w_rdata = 32'(r_mask);
        ADDR_RISE_EN: w_rdata = 32'(r_rise_en);
        ADDR_FALL_EN: w_rdata = 32'(r_fall_en);
`ifdef GPIO_LEVEL_RD_EN
        ADDR_LEVEL:   w_rdata = 32'(r_level);
`endif
        ADDR_OUT:     w_rdata = 32'(r_out);
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  assign DataOut = w_rdata;
  assign OUT     = r_out;
  assign Intr    = ~|(r_status & r_mask);

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Directed bench for gpio_event_ctrl (N_IN=4, DB_CNT=4, N_OUT=8): register table plus
// hand-timed debounce, W1C/set collision and reset sequences.
module tb_gpio_event_ctrl;

  localparam int N_IN  = 4;
  localparam int N_OUT = 8;
  localparam logic [N_OUT-1:0] OUT_RST = 8'h3C;

`ifdef GPIO_LEVEL_RD_EN
  localparam bit LVL_RD = 1'b1;
`else
  localparam bit LVL_RD = 1'b0;
`endif

  localparam logic [11:0] A_STATUS  = 12'h000;
  localparam logic [11:0] A_MASK    = 12'h004;
  localparam logic [11:0] A_RISE_EN = 12'h008;
  localparam logic [11:0] A_FALL_EN = 12'h00C;
  localparam logic [11:0] A_LEVEL   = 12'h010;
  localparam logic [11:0] A_OUT     = 12'h014;

  logic             clk;
  logic             reset;
  logic             cs_n;
  logic             rd_n;
  logic             wr_n;
  logic [11:0]      addr;
  logic [31:0]      data_in;
  logic [31:0]      data_out;
  logic [N_IN-1:0]  in_raw;
  logic [N_OUT-1:0] out_port;
  logic             intr;

  int checks;
  int errors;

  gpio_event_ctrl #(
    .N_IN   (N_IN),
    .DB_CNT (4),
    .N_OUT  (N_OUT),
    .OUT_RST(OUT_RST)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .CS_N    (cs_n),
    .RD_N    (rd_n),
    .WR_N    (wr_n),
    .Addr    (addr),
    .DataIn  (data_in),
    .DataOut (data_out),
    .IN      (in_raw),
    .OUT     (out_port),
    .Intr    (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    addr = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1;
    cs_n = 1'b1; wr_n = 1'b1;
    $display("wr addr=%03h data=%08h", a, d);
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    #1;
    d = data_out;
    cs_n = 1'b1; rd_n = 1'b1;
    $display("rd addr=%03h data=%08h", a, d);
  endtask

  task automatic check_reg(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = '0; data_in = '0; in_raw = '0;

    vecs[0]  = '{1'b1, A_MASK,    32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b0, A_MASK,    32'h0,         32'hF};
    vecs[2]  = '{1'b1, A_RISE_EN, 32'h5,         32'h0};
    vecs[3]  = '{1'b0, A_RISE_EN, 32'h0,         32'h5};
    vecs[4]  = '{1'b1, A_RISE_EN, 32'hF,         32'h0};
    vecs[5]  = '{1'b1, A_FALL_EN, 32'hFFFF_FFF0, 32'h0};
    vecs[6]  = '{1'b0, A_FALL_EN, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, A_OUT,     32'h1FF,       32'h0};
    vecs[8]  = '{1'b0, A_OUT,     32'h0,         32'hFF};
    vecs[9]  = '{1'b1, A_OUT,     32'h5A,        32'h0};
    vecs[10] = '{1'b0, A_OUT,     32'h0,         32'h5A};
    vecs[11] = '{1'b0, 12'h018,   32'h0,         32'h0};
    vecs[12] = '{1'b1, A_LEVEL,   32'hF,         32'h0};
    vecs[13] = '{1'b0, A_LEVEL,   32'h0,         32'h0};
    vecs[14] = '{1'b1, A_STATUS,  32'hF,         32'h0};
    vecs[15] = '{1'b0, A_STATUS,  32'h0,         32'h0};
    vecs[16] = '{1'b0, 12'h0FC,   32'h0,         32'h0};
    vecs[17] = '{1'b0, 12'h001,   32'h0,         32'h0};

    // Reset state
    tick(3);
    check("rst_intr_low", {31'h0, intr}, 32'h1);
    check("rst_out_port_in_reset", 32'(out_port), 32'(OUT_RST));
    reset = 1'b1;
    tick(1);
    check_reg("rst_status", A_STATUS, 32'h0);
    check_reg("rst_mask", A_MASK, 32'h0);
    check_reg("rst_rise_en", A_RISE_EN, 32'hF);
    check_reg("rst_fall_en", A_FALL_EN, 32'h0);
    check_reg("rst_out_reg", A_OUT, 32'(OUT_RST));
    check("rst_intr", {31'h0, intr}, 32'h1);

    // Register table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].a, vecs[i].d);
      end else begin
        check_reg($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
      end
    end
    check("out_port_5a", 32'(out_port), 32'h5A);
    addr = A_MASK; cs_n = 1'b0; rd_n = 1'b1;
    #1;
    check("no_rd_strobe", data_out, 32'h0);
    cs_n = 1'b1;
    tick(1);

    // Rising event on IN[1]: STATUS sets on the 6th posedge
    in_raw = 4'b0010;
    tick(5);
    check_reg("rise_status_early", A_STATUS, 32'h0);
    check("rise_intr_early", {31'h0, intr}, 32'h1);
    tick(1);
    check_reg("rise_status", A_STATUS, 32'h2);
    check("rise_intr", {31'h0, intr}, 32'h0);
    check_reg("rise_status_reread", A_STATUS, 32'h2);

    // 3-cycle glitch on IN[2]
    in_raw = 4'b0110;
    tick(3);
    in_raw = 4'b0010;
    tick(10);
    check_reg("glitch_status", A_STATUS, 32'h2);
    check_reg("glitch_level", A_LEVEL, LVL_RD ? 32'h2 : 32'h0);

    // W1C colliding with a new falling event on IN[1]: set wins
    bus_write(A_FALL_EN, 32'h2);
    in_raw = 4'b0000;
    tick(5);
    bus_write(A_STATUS, 32'h2);
    check_reg("w1c_collide", A_STATUS, 32'h2);
    bus_write(A_STATUS, 32'h2);
    check_reg("w1c_clear", A_STATUS, 32'h0);
    check("w1c_intr", {31'h0, intr}, 32'h1);

    // Falling-only enable on IN[0]
    bus_write(A_FALL_EN, 32'h1);
    bus_write(A_RISE_EN, 32'h0);
    in_raw = 4'b0001;
    tick(10);
    check_reg("fall_no_rise_evt", A_STATUS, 32'h0);
    in_raw = 4'b0000;
    tick(5);
    check_reg("fall_early", A_STATUS, 32'h0);
    tick(1);
    check_reg("fall_status", A_STATUS, 32'h1);
    check("fall_intr", {31'h0, intr}, 32'h0);
    bus_write(A_RISE_EN, 32'hF);
    check_reg("en_change_keeps", A_STATUS, 32'h1);
    bus_write(A_MASK, 32'h0);
    check("mask_off_intr", {31'h0, intr}, 32'h1);
    bus_write(A_MASK, 32'h1);
    check("mask_on_intr", {31'h0, intr}, 32'h0);
    bus_write(A_FALL_EN, 32'h0);
    bus_write(A_STATUS, 32'hF);

    // OUT write, LEVEL read, unmapped read
    bus_write(A_OUT, 32'hA5);
    check("out_port_a5", 32'(out_port), 32'hA5);
    in_raw = 4'b0011;
    tick(10);
    check_reg("level_rd", A_LEVEL, LVL_RD ? 32'h3 : 32'h0);
    check_reg("unmapped_018", 12'h018, 32'h0);
    check_reg("level_rise_status", A_STATUS, 32'h3);

    // Reset mid-debounce loses the pending count
    in_raw = 4'b0000;
    tick(10);
    bus_write(A_STATUS, 32'hF);
    in_raw = 4'b0100;
    tick(4);
    reset = 1'b0;
    #1;
    check_reg("midrst_status", A_STATUS, 32'h0);
    check("midrst_out", 32'(out_port), 32'(OUT_RST));
    in_raw = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(10);
    check_reg("midrst_no_evt", A_STATUS, 32'h0);

    // Input held high through reset: rising event DB_CNT+2 edges after release
    in_raw = 4'b0001;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(5);
    check_reg("post_rst_early", A_STATUS, 32'h0);
    tick(1);
    check_reg("post_rst_rise", A_STATUS, 32'h1);
    check("post_rst_intr", {31'h0, intr}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
